key_bounce_gen: RTL and testbench

//   Synthesizable mechanical-key emulator: the driving end of the raw key line that key_filter consumes.
//   On a press request it drives an active-low key_out in four phases: bouncy press, stable low hold,

---
 rtl/key_bounce_gen_pkg.sv | 35 +++
 rtl/key_bounce_gen_lfsr16.sv | 37 +++
 rtl/key_bounce_gen.sv | 156 +++++++++++++++
 tb/tb_key_bounce_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_bounce_gen_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
//   Definitions shared by the key emulator (key_bounce_gen, lfsr16) and the
//   key_filter debounce block that consumes the emulated key line.
//   - key_state_t   : FSM state encoding of the emulator
//   - CNT_W         : width of the phase / debounce counters
//   - LFSR_POLY     : Galois feedback mask of the 16-bit bounce generator
//   - KEY_RELEASED / KEY_PRESSED : levels of the active-low key line
// ---------------------------------------------------------------------------
package key_pkg;

    localparam int          CNT_W             = 20;
    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam logic        KEY_RELEASED      = 1'b1;
    localparam logic        KEY_PRESSED       = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS_B = 2'd1,
        HOLD    = 2'd2,
        REL_B   = 2'd3
    } key_state_t;

    // An all-zero state would lock a Galois LFSR at zero forever.
    function automatic logic [15:0] lfsr_safe_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    endfunction

    // One right shift of the Galois LFSR; the bit shifted out selects the mask.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/key_bounce_gen_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11, right shift).
//   Advances on every rising edge once reset is released.
//   Ports:
//     sys_clk    in   system clock
//     sys_rst_n  in   asynchronous, active-low reset
//     seed       in   reset value (zero is replaced by 16'hACE1)
//     q          out  current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
    import key_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lfsr_q <= lfsr_safe_seed(seed);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/key_bounce_gen.sv
// ---------------------------------------------------------------------------
// key_bounce_gen
//   Mechanical key emulator driving an active-low raw key line. A press
//   request plays one sequence: pseudo-random bounce on press, stable low
//   hold, pseudo-random bounce on release, then back to released.
//   Parameters:
//     BOUNCE_LEN  cycles of bounce per bounce phase (0 skips both)
//     HOLD_LEN    cycles of stable low (must be >= 1)
//     LFSR_SEED   reset value of the bounce generator
//   Ports:
//     sys_clk     in   system clock
//     sys_rst_n   in   asynchronous, active-low reset
//     press_req   in   start one press/release sequence (ignored when busy)
//     abort       in   drop the running sequence, no done pulse
//     key_out     out  emulated key line, 1 = released, 0 = pressed
//     busy        out  sequence in progress
//     done        out  one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module key_bounce_gen
    import key_pkg::*;
#(
    parameter logic [CNT_W-1:0] BOUNCE_LEN = 20'd50,
    parameter logic [CNT_W-1:0] HOLD_LEN   = 20'd100,
    parameter logic [15:0]      LFSR_SEED  = 16'hACE1
)(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic press_req,
    input  logic abort,
    output logic key_out,
    output logic busy,
    output logic done
);

    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_out_q, key_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [15:0] lfsr_val;
    // Only bit 0 feeds the key line; the rest stays visible for debug.
    logic [14:0] lfsr_unused;

    assign lfsr_unused = lfsr_val[15:1];

    lfsr16 u_lfsr (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .seed      (LFSR_SEED),
        .q         (lfsr_val)
    );

    // Every phase exits on cnt == 0 and the next phase reloads the counter,
    // so the counter is never decremented past zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_out_d = key_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            key_out_d = KEY_RELEASED;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    key_out_d = KEY_RELEASED;
                    busy_d    = 1'b0;
                    if (press_req) begin
                        busy_d = 1'b1;
                        if (BOUNCE_LEN != '0) begin
                            state_d   = PRESS_B;
                            cnt_d     = BOUNCE_LEN - 1'b1;
                            key_out_d = lfsr_val[0];
                        end else begin
                            state_d   = HOLD;
                            cnt_d     = HOLD_LEN - 1'b1;
                            key_out_d = KEY_PRESSED;
                        end
                    end
                end
                PRESS_B: begin
                    if (cnt_q == '0) begin
                        state_d   = HOLD;
                        cnt_d     = HOLD_LEN - 1'b1;
                        key_out_d = KEY_PRESSED;
                    end else begin
                        cnt_d     = cnt_q - 1'b1;
                        key_out_d = lfsr_val[0];
                    end
                end
                HOLD: begin
                    key_out_d = KEY_PRESSED;
                    if (cnt_q == '0) begin
                        if (BOUNCE_LEN != '0) begin
                            state_d   = REL_B;
                            cnt_d     = BOUNCE_LEN - 1'b1;
                            key_out_d = lfsr_val[0];
                        end else begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            key_out_d = KEY_RELEASED;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                REL_B: begin
                    if (cnt_q == '0) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        key_out_d = KEY_RELEASED;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        cnt_d     = cnt_q - 1'b1;
                        key_out_d = lfsr_val[0];
                    end
                end
                default: begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    key_out_d = KEY_RELEASED;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_out_q <= KEY_RELEASED;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_out_q <= key_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign key_out = key_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// ---------------------------------------------------------------------------
// tb_key_bounce_gen
//   Directed bench for key_bounce_gen. u_dut uses BOUNCE_LEN=8, HOLD_LEN=16
//   (32-cycle sequence); u_dut_z uses BOUNCE_LEN=0, HOLD_LEN=1 to cover the
//   no-bounce path and back-to-back requests. Outputs are sampled 1 ns after
//   each rising edge. The bench keeps its own copy of the bounce LFSR so that
//   the bouncy phases can be checked bit for bit.
// ---------------------------------------------------------------------------
module tb_key_bounce_gen;

    logic sys_clk;
    logic sys_rst_n;
    logic press_req, abort;
    logic key_out, busy, done;
    logic press_req_z, abort_z;
    logic key_out_z, busy_z, done_z;

    int tests_run;
    int tests_failed;

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    key_bounce_gen #(
        .BOUNCE_LEN (20'd8),
        .HOLD_LEN   (20'd16),
        .LFSR_SEED  (16'hACE1)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .press_req (press_req),
        .abort     (abort),
        .key_out   (key_out),
        .busy      (busy),
        .done      (done)
    );

    key_bounce_gen #(
        .BOUNCE_LEN (20'd0),
        .HOLD_LEN   (20'd1),
        .LFSR_SEED  (16'hACE1)
    ) u_dut_z (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .press_req (press_req_z),
        .abort     (abort_z),
        .key_out   (key_out_z),
        .busy      (busy_z),
        .done      (done_z)
    );

    // 50 MHz clock
    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    // Reference bounce generator: x^16+x^14+x^13+x^11, right shift.
    function automatic logic [15:0] ref_lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) nxt = nxt ^ 16'hB400;
        return nxt;
    endfunction

    // One rising edge; m_prev holds the LFSR value the DUT saw at that edge.
    task automatic step();
        @(posedge sys_clk);
        m_prev = m_lfsr;
        m_lfsr = ref_lfsr_next(m_lfsr);
        #1;
    endtask

    task automatic applyStimulus(input logic p, input logic a);
        press_req = p;
        abort     = a;
    endtask

    task automatic checkOutput(input string tag, input logic obs, input logic expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $display("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
            $error("[TB] check %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_key"},  key_out, 1'b1);
        checkOutput({tag, "_busy"}, busy,    1'b0);
        checkOutput({tag, "_done"}, done,    1'b0);
    endtask

    // Step k (1..32) of a running sequence: bounce on 1..8 and 25..32,
    // stable low on 9..24, busy throughout, no done.
    task automatic checkSeqStep(input int k);
        checkOutput($sformatf("seq%0d_busy", k), busy, 1'b1);
        checkOutput($sformatf("seq%0d_done", k), done, 1'b0);
        if (k >= 9 && k <= 24)
            checkOutput($sformatf("seq%0d_hold", k), key_out, 1'b0);
        else
            checkOutput($sformatf("seq%0d_bounce", k), key_out, m_prev[0]);
    endtask

    // Full 32-cycle sequence on u_dut; extra_at != 0 re-requests mid-sequence.
    task automatic runFullSequence(input int extra_at);
        applyStimulus(1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0);
        checkSeqStep(1);
        for (int k = 2; k <= 32; k++) begin
            if (k == extra_at) applyStimulus(1'b1, 1'b0);
            step();
            applyStimulus(1'b0, 1'b0);
            checkSeqStep(k);
        end
        step();
        checkOutput("end_done", done,    1'b1);
        checkOutput("end_busy", busy,    1'b0);
        checkOutput("end_key",  key_out, 1'b1);
        step();
        checkIdle("after_done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        press_req    = 1'b0;
        abort        = 1'b0;
        press_req_z  = 1'b0;
        abort_z      = 1'b0;
        m_lfsr       = 16'hACE1;
        m_prev       = 16'hACE1;

        // Reset held 20 ns
        sys_rst_n = 1'b0;
        #15;
        checkIdle("reset");
        checkOutput("reset_z_busy", busy_z, 1'b0);
        #5;
        sys_rst_n = 1'b1;

        // No request: quiet for 100 cycles
        for (int i = 0; i < 100; i++) begin
            step();
            checkIdle("quiet");
        end

        // Plain sequence
        runFullSequence(0);

        // Request during a sequence is ignored
        runFullSequence(10);

        // Abort in HOLD
        applyStimulus(1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0);
        for (int k = 2; k <= 15; k++) step();
        checkOutput("pre_abort_key", key_out, 1'b0);
        applyStimulus(1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0);
        checkIdle("abort");
        for (int i = 0; i < 20; i++) begin
            step();
            checkIdle("post_abort");
        end
        runFullSequence(0);

        // Abort in IDLE does nothing
        applyStimulus(1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0);
        checkIdle("abort_idle");

        // No-bounce instance: single hold cycle, then back-to-back request
        press_req_z = 1'b1;
        step();
        press_req_z = 1'b0;
        checkOutput("z1_key",  key_out_z, 1'b0);
        checkOutput("z1_busy", busy_z,    1'b1);
        checkOutput("z1_done", done_z,    1'b0);
        step();
        checkOutput("z1_end_key",  key_out_z, 1'b1);
        checkOutput("z1_end_busy", busy_z,    1'b0);
        checkOutput("z1_end_done", done_z,    1'b1);
        press_req_z = 1'b1;
        step();
        press_req_z = 1'b0;
        checkOutput("z2_key",  key_out_z, 1'b0);
        checkOutput("z2_busy", busy_z,    1'b1);
        checkOutput("z2_done", done_z,    1'b0);
        step();
        checkOutput("z2_end_done", done_z, 1'b1);
        checkOutput("z2_end_busy", busy_z, 1'b0);
        step();
        checkOutput("z_idle_done", done_z,    1'b0);
        checkOutput("z_idle_key",  key_out_z, 1'b1);

        // Reset in the middle of a sequence
        applyStimulus(1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0);
        for (int k = 2; k <= 12; k++) step();
        checkOutput("pre_rst_busy", busy, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        checkIdle("mid_reset");
        #8;
        sys_rst_n = 1'b1;
        m_lfsr    = 16'hACE1;
        for (int i = 0; i < 40; i++) begin
            step();
            checkIdle("post_reset");
        end

        // Sequence after reset restarts from the seed
        runFullSequence(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog against a stuck simulation
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
